cfu_input_buffer: RTL and testbench
===================================

Name: cfu_input_buffer

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO staging 32-bit words from the CFU command path toward the image-classification accelerator datapath.
- The head word is presented on read_data whenever the buffer is non-empty; read_en pops it.
- Capacity is 256 words, with an occupancy count and a synchronous soft clear.

Parameters:
- DATA_W, 32, word width.
- DEPTH, 256, capacity in words; must be a power of two.
- PTR_W, $clog2(DEPTH) = 8, read/write pointer width (derived).
- CNT_W, $clog2(DEPTH)+1 = 9, count width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous flush; same effect as rst.
- write_en  in  1  push request.
- write_data  in  DATA_W  word to push.
- write_full  out  1  high when count == DEPTH.
- read_en  in  1  pop request; acknowledges the current head.
- read_data  out  DATA_W  current head word (FWFT).
- read_data_valid  out  1  equals !read_empty.
- read_empty  out  1  high when count == 0.
- count  out  CNT_W  occupancy, 0..DEPTH.

Behaviour:
- Reset (rst or clear sampled high at a posedge):
  - wr_ptr, rd_ptr and count go to 0.
  - read_empty=1, read_data_valid=0, write_full=0, read_data=0.
  - Memory contents are not cleared.
  - rst has priority over clear; both have priority over read/write in the same cycle.
- Status outputs:
  - write_full, read_empty and read_data_valid are combinational decodes of the count register.
  - They therefore update in the same cycle as count, one posedge after the accepted operation.
- Write acceptance:
  - push = write_en && !write_full.
  - On push: mem[wr_ptr] <= write_data; wr_ptr increments modulo DEPTH.
  - A write while full is silently dropped; no state changes.
- Read acceptance:
  - pop = read_en && !read_empty.
  - On pop: rd_ptr increments modulo DEPTH.
  - A read while empty is ignored.
- Count update:
  - count += push - pop.
  - When push and pop occur together, count is unchanged and both pointers advance.
- Full and simultaneous read+write:
  - write_full is evaluated from the pre-edge count.
  - Therefore read_en+write_en while full pops one and drops the write; count becomes DEPTH-1.
- Empty and simultaneous read+write:
  - pop is blocked while empty; the write still lands.
  - count becomes 1 and the new word appears on read_data after that edge.
- FWFT data path:
  - read_data = mem[rd_ptr] when !read_empty, else 0. This is an asynchronous read of the register array.
  - After a push into an empty buffer, the word is visible on read_data in the cycle after that edge (zero extra latency).
  - After a pop, the next word is visible in the cycle after that edge.
- Wrap-around: pointers are PTR_W bits and wrap naturally. Order is preserved across any number of wraps.
- Mid-operation reset or clear discards all contents, regardless of pending write_en/read_en in that cycle.
- No combinational path from write_en/read_en to any output.

Optional Feature:
- Macro: CFU_INPUT_BUFFER_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): sticky; sets on write_en && write_full.
  - underflow (1 bit): sticky; sets on read_en && read_empty.
  - Both clear on rst or clear.
- When undefined, these ports and their logic are absent, and dropped operations leave no trace.

Decomposition:
- Package cfu_input_buffer_pkg holds:
  - DATA_W, DEPTH, PTR_W and CNT_W constants.
  - Typedefs word_t (logic [DATA_W-1:0]), ptr_t and cnt_t.
- One sub-module, cfu_input_buffer_mem:
  - DEPTH x DATA_W register array.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- The top level holds the pointers, count, status decode and optional flags.

Test Plan:
- Basic order: after reset+clear, push 0xA0000000..0xA0000007, then pop 8 → each head matches before its pop. Afterwards read_empty=1, read_data_valid=0, count=0.
- FWFT: push 0xBEEF0001 and 0xBEEF0002 → read_data_valid=1 and read_data=0xBEEF0001 without read_en. One pop → read_data=0xBEEF0002.
- Simultaneous: push 0xC0000001..3 (count=3), then read_en+write_en with 0xC0000004 in one cycle → count stays 3. Subsequent heads are 0xC0000002, 0xC0000003, 0xC0000004.
- Clear: push 0xDEAD0001 and 0xDEAD0002 (count=2), pulse clear → count=0, read_empty=1, read_data_valid=0.
- Full: push 0x10000000+i for i=0..255 → count=256, write_full=1. Push 0xDEADDEAD → count stays 256. One pop → count=255, write_full=0. Push 0xFEEDFEED → count=256.
- Wrap: clear, push 0x50000000..4, pop 2 (count=3), push 0x50000005 and 0x50000006 (count=5) → pops return 0x50000002..0x50000006, then empty. Repeat with 300 interleaved push/pops to cross the pointer wrap.

Source files
------------

// File: rtl/cfu_input_buffer_pkg.sv
// cfu_input_buffer_pkg
// Shared constants and types for the CFU input buffer: word width, depth,
// and the pointer/count widths derived from the depth.
// Used by cfu_input_buffer_if, cfu_input_buffer_mem and cfu_input_buffer.
package cfu_input_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/cfu_input_buffer_if.sv
// cfu_input_buffer_if
// Push/pop handshake and status bundle of the CFU input buffer.
//   write_en/write_data/write_full        : push side
//   read_en/read_data/read_data_valid/
//   read_empty                            : pop side (FWFT head)
//   count                                 : occupancy 0..DEPTH
// With CFU_INPUT_BUFFER_ERR_FLAGS_EN defined, sticky overflow/underflow
// flags are added.
// Modports: slave = the buffer, master = the producer/consumer driving it.
interface cfu_input_buffer_if;
  import cfu_input_buffer_pkg::*;

  logic  write_en;
  word_t write_data;
  logic  write_full;
  logic  read_en;
  word_t read_data;
  logic  read_data_valid;
  logic  read_empty;
  cnt_t  count;
`ifdef CFU_INPUT_BUFFER_ERR_FLAGS_EN
  logic  overflow;
  logic  underflow;
`endif

  modport slave (
    input  write_en, write_data, read_en,
    output write_full, read_data, read_data_valid, read_empty, count
`ifdef CFU_INPUT_BUFFER_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );

  modport master (
    output write_en, write_data, read_en,
    input  write_full, read_data, read_data_valid, read_empty, count
`ifdef CFU_INPUT_BUFFER_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

endinterface

// File: rtl/cfu_input_buffer_mem.sv
// cfu_input_buffer_mem
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Contents are never reset.
// Ports:
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational from raddr)
module cfu_input_buffer_mem
  import cfu_input_buffer_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  ptr_t  waddr,
  input  word_t wdata,
  input  ptr_t  raddr,
  output word_t rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cfu_input_buffer.sv
// cfu_input_buffer
// First-word-fall-through FIFO staging 32-bit CFU command words toward the
// classifier datapath. The head word sits on read_data whenever the buffer
// is non-empty; read_en pops it. Status outputs decode the count register,
// so nothing on the outputs depends combinationally on write_en/read_en.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset (priority over clear)
//   clear in  synchronous flush, same effect as rst
//   bus   cfu_input_buffer_if.slave handshake/status bundle
// Optional: CFU_INPUT_BUFFER_ERR_FLAGS_EN adds sticky overflow/underflow.
module cfu_input_buffer
  import cfu_input_buffer_pkg::*;
(
  input logic               clk,
  input logic               rst,
  input logic               clear,
  cfu_input_buffer_if.slave bus
);

  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  cnt_t  count_q;
  word_t mem_rdata;
  logic  full;
  logic  empty;
  logic  push;
  logic  pop;
  logic  flush;

  assign full  = (count_q == cnt_t'(DEPTH));
  assign empty = (count_q == '0);
  assign flush = rst || clear;

  // Both qualifiers use the pre-edge status, so read+write while full pops
  // and drops the write, and read+write while empty only pushes.
  assign push = bus.write_en && !full;
  assign pop  = bus.read_en && !empty;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // A write coinciding with reset/clear must not land in the array either.
  cfu_input_buffer_mem u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (bus.write_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign bus.write_full      = full;
  assign bus.read_empty      = empty;
  assign bus.read_data_valid = !empty;
  assign bus.count           = count_q;
  // Stale array contents are masked while empty.
  assign bus.read_data       = empty ? '0 : mem_rdata;

`ifdef CFU_INPUT_BUFFER_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write_en && full) overflow_q  <= 1'b1;
      if (bus.read_en && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_cfu_input_buffer.sv
// tb_cfu_input_buffer
// Directed test of cfu_input_buffer. Inputs change 1 ns after a rising edge
// and outputs are sampled 1 ns after the following rising edge.
module tb_cfu_input_buffer;
  import cfu_input_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  cfu_input_buffer_if bus_if ();

  cfu_input_buffer dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.write_en   = 1'b0;
    bus_if.read_en    = 1'b0;
    bus_if.write_data = '0;
  endtask

  task automatic push(input word_t d);
    bus_if.write_en   = 1'b1;
    bus_if.write_data = d;
    cycle();
    idle_inputs();
  endtask

  task automatic pop();
    bus_if.read_en = 1'b1;
    cycle();
    idle_inputs();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    vectors++;
    if (bus_if.count !== cnt_t'(0)) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", bus_if.count);
    end
    vectors++;
    if (bus_if.read_empty !== 1'b1 || bus_if.read_data_valid !== 1'b0 || bus_if.write_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: empty=%b valid=%b full=%b want 1 0 0",
               bus_if.read_empty, bus_if.read_data_valid, bus_if.write_full);
    end
    vectors++;
    if (bus_if.read_data !== word_t'(0)) begin
      miscompares++; $display("FAIL reset_data: got %h want 00000000", bus_if.read_data);
    end
`ifdef CFU_INPUT_BUFFER_ERR_FLAGS_EN
    vectors++;
    if (bus_if.overflow !== 1'b0 || bus_if.underflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: ovf=%b unf=%b want 0 0", bus_if.overflow, bus_if.underflow);
    end
`endif
  endtask

  task automatic test_basic_order();
    pulse_clear();
    for (int i = 0; i < 8; i++) push(32'hA000_0000 + i);
    vectors++;
    if (bus_if.count !== cnt_t'(8)) begin
      miscompares++; $display("FAIL basic_count: got %0d want 8", bus_if.count);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (bus_if.read_data !== 32'hA000_0000 + i) begin
        miscompares++; $display("FAIL basic_head%0d: got %h want %h", i, bus_if.read_data, 32'hA000_0000 + i);
      end
      pop();
    end
    vectors++;
    if (bus_if.read_empty !== 1'b1 || bus_if.read_data_valid !== 1'b0 || bus_if.count !== cnt_t'(0)) begin
      miscompares++;
      $display("FAIL basic_drained: empty=%b valid=%b count=%0d want 1 0 0",
               bus_if.read_empty, bus_if.read_data_valid, bus_if.count);
    end
  endtask

  task automatic test_fwft();
    push(32'hBEEF_0001);
    vectors++;
    if (bus_if.read_data_valid !== 1'b1 || bus_if.read_data !== 32'hBEEF_0001) begin
      miscompares++;
      $display("FAIL fwft_first: valid=%b data=%h want 1 beef0001", bus_if.read_data_valid, bus_if.read_data);
    end
    push(32'hBEEF_0002);
    cycle();
    vectors++;
    if (bus_if.read_data !== 32'hBEEF_0001 || bus_if.count !== cnt_t'(2)) begin
      miscompares++;
      $display("FAIL fwft_hold: data=%h count=%0d want beef0001 2", bus_if.read_data, bus_if.count);
    end
    pop();
    vectors++;
    if (bus_if.read_data !== 32'hBEEF_0002) begin
      miscompares++; $display("FAIL fwft_next: got %h want beef0002", bus_if.read_data);
    end
    pop();
  endtask

  task automatic test_simultaneous();
    pulse_clear();
    // read+write while empty: only the write lands
    bus_if.write_en = 1'b1; bus_if.read_en = 1'b1; bus_if.write_data = 32'hC0DE_0000;
    cycle();
    idle_inputs();
    vectors++;
    if (bus_if.count !== cnt_t'(1) || bus_if.read_data !== 32'hC0DE_0000) begin
      miscompares++;
      $display("FAIL simul_empty: count=%0d data=%h want 1 c0de0000", bus_if.count, bus_if.read_data);
    end
    pulse_clear();
    for (int i = 1; i <= 3; i++) push(32'hC000_0000 + i);
    bus_if.write_en = 1'b1; bus_if.read_en = 1'b1; bus_if.write_data = 32'hC000_0004;
    cycle();
    idle_inputs();
    vectors++;
    if (bus_if.count !== cnt_t'(3)) begin
      miscompares++; $display("FAIL simul_count: got %0d want 3", bus_if.count);
    end
    for (int i = 2; i <= 4; i++) begin
      vectors++;
      if (bus_if.read_data !== 32'hC000_0000 + i) begin
        miscompares++; $display("FAIL simul_head%0d: got %h want %h", i, bus_if.read_data, 32'hC000_0000 + i);
      end
      pop();
    end
  endtask

  task automatic test_clear();
    pulse_clear();
    push(32'hDEAD_0001);
    push(32'hDEAD_0002);
    vectors++;
    if (bus_if.count !== cnt_t'(2)) begin
      miscompares++; $display("FAIL clear_pre: count=%0d want 2", bus_if.count);
    end
    pulse_clear();
    vectors++;
    if (bus_if.count !== cnt_t'(0) || bus_if.read_empty !== 1'b1 || bus_if.read_data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_post: count=%0d empty=%b valid=%b want 0 1 0",
               bus_if.count, bus_if.read_empty, bus_if.read_data_valid);
    end
    // pop on empty is ignored
    pop();
    vectors++;
    if (bus_if.count !== cnt_t'(0) || bus_if.read_empty !== 1'b1) begin
      miscompares++; $display("FAIL pop_empty: count=%0d empty=%b want 0 1", bus_if.count, bus_if.read_empty);
    end
`ifdef CFU_INPUT_BUFFER_ERR_FLAGS_EN
    vectors++;
    if (bus_if.underflow !== 1'b1) begin
      miscompares++; $display("FAIL underflow_set: got %b want 1", bus_if.underflow);
    end
`endif
    // reset with pending read+write discards everything
    push(32'hDEAD_0003);
    rst = 1'b1;
    bus_if.write_en = 1'b1; bus_if.read_en = 1'b1; bus_if.write_data = 32'hDEAD_0004;
    cycle();
    rst = 1'b0;
    idle_inputs();
    vectors++;
    if (bus_if.count !== cnt_t'(0) || bus_if.read_empty !== 1'b1 || bus_if.read_data !== word_t'(0)) begin
      miscompares++;
      $display("FAIL reset_midop: count=%0d empty=%b data=%h want 0 1 00000000",
               bus_if.count, bus_if.read_empty, bus_if.read_data);
    end
  endtask

  task automatic test_full();
    pulse_clear();
    for (int i = 0; i < 256; i++) push(32'h1000_0000 + i);
    vectors++;
    if (bus_if.count !== cnt_t'(256) || bus_if.write_full !== 1'b1) begin
      miscompares++; $display("FAIL full_fill: count=%0d full=%b want 256 1", bus_if.count, bus_if.write_full);
    end
    push(32'hDEAD_DEAD);
    vectors++;
    if (bus_if.count !== cnt_t'(256) || bus_if.read_data !== 32'h1000_0000) begin
      miscompares++;
      $display("FAIL full_drop: count=%0d head=%h want 256 10000000", bus_if.count, bus_if.read_data);
    end
`ifdef CFU_INPUT_BUFFER_ERR_FLAGS_EN
    vectors++;
    if (bus_if.overflow !== 1'b1) begin
      miscompares++; $display("FAIL overflow_set: got %b want 1", bus_if.overflow);
    end
`endif
    pop();
    vectors++;
    if (bus_if.count !== cnt_t'(255) || bus_if.write_full !== 1'b0) begin
      miscompares++; $display("FAIL full_pop: count=%0d full=%b want 255 0", bus_if.count, bus_if.write_full);
    end
    push(32'hFEED_FEED);
    vectors++;
    if (bus_if.count !== cnt_t'(256) || bus_if.write_full !== 1'b1) begin
      miscompares++; $display("FAIL full_refill: count=%0d full=%b want 256 1", bus_if.count, bus_if.write_full);
    end
    // read+write while full: pop happens, write dropped
    bus_if.write_en = 1'b1; bus_if.read_en = 1'b1; bus_if.write_data = 32'h0BAD_0BAD;
    cycle();
    idle_inputs();
    vectors++;
    if (bus_if.count !== cnt_t'(255) || bus_if.read_data !== 32'h1000_0002) begin
      miscompares++;
      $display("FAIL full_simul: count=%0d head=%h want 255 10000002", bus_if.count, bus_if.read_data);
    end
    // drain; the last word must be FEEDFEED, not the dropped 0BAD0BAD
    for (int i = 0; i < 254; i++) pop();
    vectors++;
    if (bus_if.count !== cnt_t'(1) || bus_if.read_data !== 32'hFEED_FEED) begin
      miscompares++;
      $display("FAIL full_tail: count=%0d head=%h want 1 feedfeed", bus_if.count, bus_if.read_data);
    end
    pop();
  endtask

  task automatic test_wrap();
    pulse_clear();
    for (int i = 0; i < 5; i++) push(32'h5000_0000 + i);
    pop();
    pop();
    vectors++;
    if (bus_if.count !== cnt_t'(3)) begin
      miscompares++; $display("FAIL wrap_mid: count=%0d want 3", bus_if.count);
    end
    push(32'h5000_0005);
    push(32'h5000_0006);
    vectors++;
    if (bus_if.count !== cnt_t'(5)) begin
      miscompares++; $display("FAIL wrap_refill: count=%0d want 5", bus_if.count);
    end
    for (int i = 2; i <= 6; i++) begin
      vectors++;
      if (bus_if.read_data !== 32'h5000_0000 + i) begin
        miscompares++; $display("FAIL wrap_head%0d: got %h want %h", i, bus_if.read_data, 32'h5000_0000 + i);
      end
      pop();
    end
    vectors++;
    if (bus_if.read_empty !== 1'b1 || bus_if.count !== cnt_t'(0)) begin
      miscompares++; $display("FAIL wrap_empty: empty=%b count=%0d want 1 0", bus_if.read_empty, bus_if.count);
    end
    // 300 interleaved push+pop cycles carry both pointers past the wrap
    push(32'h6000_0000);
    for (int i = 1; i < 300; i++) begin
      vectors++;
      if (bus_if.read_data !== 32'h6000_0000 + i - 1 || bus_if.count !== cnt_t'(1)) begin
        miscompares++;
        $display("FAIL wrap_stream%0d: head=%h count=%0d want %h 1",
                 i, bus_if.read_data, bus_if.count, 32'h6000_0000 + i - 1);
      end
      bus_if.write_en = 1'b1; bus_if.read_en = 1'b1; bus_if.write_data = 32'h6000_0000 + i;
      cycle();
      idle_inputs();
    end
    vectors++;
    if (bus_if.read_data !== 32'h6000_012B || bus_if.count !== cnt_t'(1)) begin
      miscompares++;
      $display("FAIL wrap_final: head=%h count=%0d want 6000012b 1", bus_if.read_data, bus_if.count);
    end
    pop();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_order();
    test_fwft();
    test_simultaneous();
    test_clear();
    test_full();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
